eth_tx_arbiter: RTL and testbench
=================================

// Module: eth_tx_arbiter
// PURPOSE
// - Shares the single 64-bit Ethernet TX AXI-stream (toward the MAC) between NUM_SRC frame sources (e.g. completion path, DMA request path).
// - Frame-atomic round-robin: a grant is held from first beat to the accepted tlast beat, then an optional inter-frame gap is inserted.
// - Output is registered through a 2-entry skid slice so tready never combinationally crosses the block.
// PARAMETERS
// - NUM_SRC     2   number of requesting sources (1..8)
// - DATA_WIDTH  64  tdata width; KEEP_WIDTH = DATA_WIDTH/8
// - GAP_CYCLES  0   idle cycles forced after each frame (0..255); 0 = back-to-back
// PORTS
// - eth_clk        in   1                  single clock for all logic
// - sys_rst        in   1                  reset, asynchronous, active-high
// - src_tvalid     in   NUM_SRC            per-source beat valid
// - src_tdata      in   NUM_SRC*64         per-source data, source i at [64*i +: 64]
// - src_tkeep      in   NUM_SRC*8          per-source byte enables, source i at [8*i +: 8]
// - src_tlast      in   NUM_SRC            per-source last beat of frame
// - src_tuser      in   NUM_SRC            per-source abort/error flag, forwarded
// - src_tready     out  NUM_SRC            per-source ready; only granted bit can be 1
// - eth_tx_tvalid  out  1                  to MAC
// - eth_tx_tdata   out  64
// - eth_tx_tkeep   out  8
// - eth_tx_tlast   out  1
// - eth_tx_tuser   out  1
// - eth_tx_tready  in   1                  from MAC
// - grant_id       out  $clog2(NUM_SRC)    current/last granted source (debug)
// - frame_cnt      out  32                 frames forwarded (tlast accepted at output), wraps 2^32-1 -> 0
// BEHAVIOUR
// - Reset (async assert, sync deassert handled upstream): state=IDLE, rr_ptr=0, grant_id=0, gap_cnt=0, frame_cnt=0, slice empty; eth_tx_tvalid=0, tlast/tuser/tkeep/tdata=0, src_tready=0, all immediately.
// - FSM: IDLE -> XFER -> (GAP) -> IDLE.
// - IDLE: if any src_tvalid, grant = first asserted index searching rr_ptr, rr_ptr+1, ... mod NUM_SRC; register grant_id, rr_ptr <= grant+1 mod NUM_SRC; go XFER. src_tready=0 in IDLE (1-cycle arbitration latency).
// - XFER: src_tready[grant] = slice input ready; beat accepted when src_tvalid&src_tready. Accepted beat with src_tlast=1 -> GAP (gap_cnt<=GAP_CYCLES-1) if GAP_CYCLES>0 else IDLE.
// - Grant never changes mid-frame regardless of other requests; a source dropping tvalid mid-frame just stalls (no timeout).
// - GAP: src_tready=0; gap_cnt decrements each cycle; at 0 -> IDLE. Gap counts from input-side tlast acceptance.
// - Single-beat frame (tvalid&tlast on first beat) is legal: XFER lasts one accepted beat.
// - Slice: 2-entry skid; full throughput (1 beat/cycle) when eth_tx_tready=1; input ready = not full; latency src->eth_tx 1 cycle; data, keep, last, user unmodified, order preserved.
// - eth_tx_tvalid, once high, holds with stable payload until eth_tx_tready (AXI-stream rule).
// - frame_cnt increments on eth_tx_tvalid&eth_tx_tready&eth_tx_tlast, including tuser=1 frames.
// - Non-granted sources: src_tready=0 always; their tvalid may stay high indefinitely.
// - Reset mid-frame: in-flight frame discarded, MAC sees truncated frame with no tlast; MAC side treats it as aborted. Arbitration restarts from source 0.
// - NUM_SRC=1: arbiter degenerates to fixed grant, same FSM and latency.
// STRUCTURE
// - eth_pkg (shared): ETH_DATA_WIDTH=64, ETH_KEEP_WIDTH=8 constants; typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_GAP} eth_arb_state_t.
// - Sub-module axis_skid_slice (64b data + 8b keep + last + user, 2 entries), reusable on RX paths.
// - Round-robin pick as a function in this file; no further sub-modules.
// TESTING
// - Single source 0, 8-beat NetTLP frame (last tkeep 8'h0F), tready=1 -> 8 beats out in order, first beat 2 cycles after first tvalid, frame_cnt=1.
// - Both sources hold 3 frames each, GAP_CYCLES=0 -> output frames alternate 0,1,0,1,0,1; no beat interleaving; frame_cnt=6.
// - Source 1 raises tvalid during source 0 mid-frame -> src_tready[1]=0 until source 0 tlast accepted; source 1 frame follows.
// - eth_tx_tready toggles 1,0,0,1 pseudo-random over a 6-frame burst -> payload bit-identical to input, tvalid never drops without handshake.
// - GAP_CYCLES=12 -> exactly 12 cycles with src_tready=0 after each tlast before next grant cycle.
// - Assert sys_rst at beat 4 of 8 -> eth_tx_tvalid=0 same cycle, frame_cnt=0; after release a new frame from source 1 forwards cleanly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet datapath constants and the TX arbiter state encoding.
package eth_pkg;
    localparam int ETH_DATA_WIDTH = 64;
    localparam int ETH_KEEP_WIDTH = ETH_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER,
        ARB_GAP
    } eth_arb_state_t;
endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry AXI-stream register slice: registered output, registered input ready,
// one beat per cycle sustained, payload (data/keep/last/user) passed unmodified.
module axis_skid_slice
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = ETH_DATA_WIDTH,
    parameter int KEEP_WIDTH = ETH_KEEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    output logic                  s_tready,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tuser,
    input  logic                  m_tready
);
    // Handshake: a beat moves on a clock edge where valid && ready; valid never
    // waits on ready, and once raised it holds with a stable payload until taken.
    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 2;

    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          main_vld;
    logic          skid_vld;
    logic          s_push;
    logic [PW-1:0] s_word;

    assign s_tready = !skid_vld;
    assign s_push   = s_tvalid && s_tready;
    assign s_word   = {s_tuser, s_tlast, s_tkeep, s_tdata};

    // The skid entry only fills while the output register is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (m_tready || !main_vld) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= s_push;
                if (s_push) begin
                    main_q <= s_word;
                end
            end
        end else if (s_push) begin
            skid_q   <= s_word;
            skid_vld <= 1'b1;
        end
    end

    assign m_tvalid = main_vld;
    assign {m_tuser, m_tlast, m_tkeep, m_tdata} = main_q;
endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one Ethernet TX AXI-stream among
// NUM_SRC sources, with optional inter-frame gap and a registered output slice.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int  NUM_SRC    = 2,
    parameter int  DATA_WIDTH = ETH_DATA_WIDTH,
    parameter int  GAP_CYCLES = 0,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int GRANT_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          eth_clk,
    input  logic                          sys_rst,
    input  logic [NUM_SRC-1:0]            src_tvalid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0] src_tkeep,
    input  logic [NUM_SRC-1:0]            src_tlast,
    input  logic [NUM_SRC-1:0]            src_tuser,
    output logic [NUM_SRC-1:0]            src_tready,
    output logic                          eth_tx_tvalid,
    output logic [DATA_WIDTH-1:0]         eth_tx_tdata,
    output logic [KEEP_WIDTH-1:0]         eth_tx_tkeep,
    output logic                          eth_tx_tlast,
    output logic                          eth_tx_tuser,
    input  logic                          eth_tx_tready,
    output logic [GRANT_W-1:0]            grant_id,
    output logic [31:0]                   frame_cnt,
    output eth_arb_state_t                arb_state
);
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    // First requesting index at or after ptr, wrapping modulo NUM_SRC.
    function automatic logic [GRANT_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                   input logic [GRANT_W-1:0] ptr);
        logic found;
        int   idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (!found && req[idx]) begin
                rr_pick = GRANT_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    eth_arb_state_t     state_q;
    eth_arb_state_t     state_d;
    logic [GRANT_W-1:0] rr_ptr;
    logic [GRANT_W-1:0] pick;
    logic [7:0]         gap_cnt;
    logic               slice_in_valid;
    logic               slice_in_ready;
    logic               beat_acc;
    logic               sel_last;

    assign pick      = rr_pick(src_tvalid, rr_ptr);
    assign sel_last  = src_tlast[grant_id];
    assign arb_state = state_q;

    always_comb begin
        state_d        = state_q;
        src_tready     = '0;
        slice_in_valid = 1'b0;
        beat_acc       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|src_tvalid) begin
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                src_tready[grant_id] = slice_in_ready;
                slice_in_valid       = src_tvalid[grant_id];
                beat_acc             = slice_in_valid && slice_in_ready;
                if (beat_acc && sel_last) begin
                    state_d = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
                end
            end
            ARB_GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge eth_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            gap_cnt   <= 8'd0;
            frame_cnt <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && |src_tvalid) begin
                grant_id <= pick;
                rr_ptr   <= GRANT_W'((int'(pick) + 1) % NUM_SRC);
            end
            // Gap is timed from the input-side tlast, not from the MAC handshake.
            if (beat_acc && sel_last) begin
                gap_cnt <= GAP_LOAD;
            end else if (state_q == ARB_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            if (eth_tx_tvalid && eth_tx_tready && eth_tx_tlast) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

    axis_skid_slice #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_slice (
        .clk     (eth_clk),
        .rst     (sys_rst),
        .s_tvalid(slice_in_valid),
        .s_tdata (src_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH]),
        .s_tkeep (src_tkeep[int'(grant_id)*KEEP_WIDTH +: KEEP_WIDTH]),
        .s_tlast (sel_last),
        .s_tuser (src_tuser[grant_id]),
        .s_tready(slice_in_ready),
        .m_tvalid(eth_tx_tvalid),
        .m_tdata (eth_tx_tdata),
        .m_tkeep (eth_tx_tkeep),
        .m_tlast (eth_tx_tlast),
        .m_tuser (eth_tx_tuser),
        .m_tready(eth_tx_tready)
    );
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench for eth_tx_arbiter: instance 0 back-to-back, instance 1 with a
// 12-cycle inter-frame gap, checked against a frame-level round-robin model.
module tb_eth_tx_arbiter;
    import eth_pkg::*;

    localparam int NS = 2;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int BW = DW + KW + 2;
    localparam int GAP_A = 0;
    localparam int GAP_B = 12;

    // ---------------- clock / reset ----------------
    logic eth_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 eth_clk = ~eth_clk;

    logic [NS-1:0]    src_tvalid [2];
    logic [NS*DW-1:0] src_tdata  [2];
    logic [NS*KW-1:0] src_tkeep  [2];
    logic [NS-1:0]    src_tlast  [2];
    logic [NS-1:0]    src_tuser  [2];
    logic [NS-1:0]    src_tready [2];
    logic             eth_tx_tvalid [2];
    logic [DW-1:0]    eth_tx_tdata  [2];
    logic [KW-1:0]    eth_tx_tkeep  [2];
    logic             eth_tx_tlast  [2];
    logic             eth_tx_tuser  [2];
    logic             eth_tx_tready [2];
    logic [0:0]       grant_id  [2];
    logic [31:0]      frame_cnt [2];
    eth_arb_state_t   arb_state [2];

    eth_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .GAP_CYCLES(GAP_A)) dut_a (
        .eth_clk(eth_clk), .sys_rst(sys_rst),
        .src_tvalid(src_tvalid[0]), .src_tdata(src_tdata[0]), .src_tkeep(src_tkeep[0]),
        .src_tlast(src_tlast[0]), .src_tuser(src_tuser[0]), .src_tready(src_tready[0]),
        .eth_tx_tvalid(eth_tx_tvalid[0]), .eth_tx_tdata(eth_tx_tdata[0]),
        .eth_tx_tkeep(eth_tx_tkeep[0]), .eth_tx_tlast(eth_tx_tlast[0]),
        .eth_tx_tuser(eth_tx_tuser[0]), .eth_tx_tready(eth_tx_tready[0]),
        .grant_id(grant_id[0]), .frame_cnt(frame_cnt[0]), .arb_state(arb_state[0])
    );

    eth_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .GAP_CYCLES(GAP_B)) dut_b (
        .eth_clk(eth_clk), .sys_rst(sys_rst),
        .src_tvalid(src_tvalid[1]), .src_tdata(src_tdata[1]), .src_tkeep(src_tkeep[1]),
        .src_tlast(src_tlast[1]), .src_tuser(src_tuser[1]), .src_tready(src_tready[1]),
        .eth_tx_tvalid(eth_tx_tvalid[1]), .eth_tx_tdata(eth_tx_tdata[1]),
        .eth_tx_tkeep(eth_tx_tkeep[1]), .eth_tx_tlast(eth_tx_tlast[1]),
        .eth_tx_tuser(eth_tx_tuser[1]), .eth_tx_tready(eth_tx_tready[1]),
        .grant_id(grant_id[1]), .frame_cnt(frame_cnt[1]), .arb_state(arb_state[1])
    );

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Source beat word: {first, user, last, keep, data}
    logic [BW:0] src_mem [2][NS][64];
    int src_wr [2][NS];
    int src_rd [2][NS];
    int fr_start [2][NS][16];
    int fr_len   [2][NS][16];
    int fr_cnt   [2][NS];
    int fr_used  [2][NS];
    bit hold     [2][NS];

    logic [BW-1:0] exp_q0 [$];
    logic [BW-1:0] exp_q1 [$];
    int exp_frames [2];
    int model_ptr  [2];

    logic [NS-1:0] acc [2];
    int owner [2];
    bit stalled [2];
    logic [BW-1:0] prev_word [2];
    bit gm_active [2];
    int gm_cnt [2];
    int lat_in [2];
    int lat_out [2];
    bit bubbles, rand_rdy, meas_en;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus / model ----------------
    task automatic add_frame(input int d, input int s, input int len, input logic [7:0] lkeep);
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic last, user;
        fr_start[d][s][fr_cnt[d][s]] = src_wr[d][s];
        fr_len[d][s][fr_cnt[d][s]]   = len;
        for (int b = 0; b < len; b++) begin
            data = {4'(s), 4'(d), 8'(fr_cnt[d][s]), 8'(b), 32'($urandom), 8'($urandom)};
            last = (b == len - 1);
            keep = !last ? 8'hFF : (lkeep != 8'h00) ? lkeep : 8'($urandom_range(1, 255));
            user = last && ($urandom_range(0, 3) == 0);
            src_mem[d][s][src_wr[d][s]] = {(b == 0), user, last, keep, data};
            src_wr[d][s]++;
        end
        fr_cnt[d][s]++;
    endtask

    task automatic push_exp(input int d, input logic [BW-1:0] w);
        if (d == 0) exp_q0.push_back(w);
        else        exp_q1.push_back(w);
    endtask

    // Whole frames leave in round-robin order over sources with frames queued.
    task automatic model(input int d);
        int ptr, pick, st, s;
        bit more;
        ptr  = model_ptr[d];
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int i = 0; i < NS; i++) begin
                s = (ptr + i) % NS;
                if (pick < 0 && fr_used[d][s] < fr_cnt[d][s]) pick = s;
            end
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                st = fr_start[d][pick][fr_used[d][pick]];
                for (int b = 0; b < fr_len[d][pick][fr_used[d][pick]]; b++)
                    push_exp(d, src_mem[d][pick][st + b][BW-1:0]);
                fr_used[d][pick]++;
                exp_frames[d]++;
                ptr = (pick + 1) % NS;
            end
        end
        model_ptr[d] = ptr;
    endtask

    task automatic drive(input int d);
        logic [BW:0] w;
        for (int s = 0; s < NS; s++) begin
            w = '0;
            src_tvalid[d][s] = 1'b0;
            if (src_rd[d][s] < src_wr[d][s] && !hold[d][s]) begin
                w = src_mem[d][s][src_rd[d][s]];
                src_tvalid[d][s] = 1'b1;
                if (bubbles && !w[BW] && $urandom_range(0, 3) == 0) src_tvalid[d][s] = 1'b0;
            end
            src_tdata[d][s*DW +: DW] = w[DW-1:0];
            src_tkeep[d][s*KW +: KW] = w[DW +: KW];
            src_tlast[d][s] = w[DW+KW];
            src_tuser[d][s] = w[DW+KW+1];
        end
        eth_tx_tready[d] = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic clear_state();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < NS; s++) begin
                src_wr[d][s] = 0; src_rd[d][s] = 0;
                fr_cnt[d][s] = 0; fr_used[d][s] = 0; hold[d][s] = 1'b0;
            end
            exp_frames[d] = 0; model_ptr[d] = 0; owner[d] = -1;
            stalled[d] = 1'b0; gm_active[d] = 1'b0; gm_cnt[d] = 0;
            lat_in[d] = -1; lat_out[d] = -1; acc[d] = '0;
        end
        exp_q0.delete();
        exp_q1.delete();
        bubbles = 1'b0; rand_rdy = 1'b0; meas_en = 1'b0;
        for (int d = 0; d < 2; d++) drive(d);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        clear_state();
        repeat (2) @(posedge eth_clk);
        @(negedge eth_clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_tvalid[%0d]", d), eth_tx_tvalid[d], 0);
            check($sformatf("rst_tdata[%0d]", d), eth_tx_tdata[d], 0);
            check($sformatf("rst_ctl[%0d]", d), {eth_tx_tkeep[d], eth_tx_tlast[d], eth_tx_tuser[d]}, 0);
            check($sformatf("rst_src_tready[%0d]", d), src_tready[d], 0);
            check($sformatf("rst_grant[%0d]", d), grant_id[d], 0);
            check($sformatf("rst_frame_cnt[%0d]", d), frame_cnt[d], 0);
            check($sformatf("rst_state[%0d]", d), arb_state[d], ARB_IDLE);
        end
        sys_rst = 1'b0;
    endtask

    // ---------------- per-cycle monitor / scoreboard ----------------
    task automatic sample(input int d);
        logic [BW-1:0] word, exp;
        logic [NS-1:0] m;
        acc[d] = src_tvalid[d] & src_tready[d];
        if (owner[d] >= 0) begin
            m = NS'(1) << owner[d];
            check($sformatf("grant_hold[%0d]", d), src_tready[d] & ~m, 0);
        end
        if (lat_in[d] < 0 && |src_tvalid[d]) lat_in[d] = cyc;
        if (lat_out[d] < 0 && eth_tx_tvalid[d]) lat_out[d] = cyc;
        word = {eth_tx_tuser[d], eth_tx_tlast[d], eth_tx_tkeep[d], eth_tx_tdata[d]};
        if (stalled[d]) begin
            check($sformatf("tvalid_hold[%0d]", d), eth_tx_tvalid[d], 1);
            check($sformatf("payload_hold[%0d]", d), word, prev_word[d]);
        end
        if (eth_tx_tvalid[d] && eth_tx_tready[d]) begin
            exp = {BW{1'bx}};
            if (d == 0 && exp_q0.size() != 0) exp = exp_q0.pop_front();
            if (d == 1 && exp_q1.size() != 0) exp = exp_q1.pop_front();
            check($sformatf("beat[%0d]", d), word, exp);
        end
        stalled[d]   = eth_tx_tvalid[d] && !eth_tx_tready[d];
        prev_word[d] = word;
        if (gm_active[d]) begin
            if (src_tready[d] == '0) begin
                gm_cnt[d]++;
            end else begin
                if (meas_en)
                    check($sformatf("gap_len[%0d]", d), gm_cnt[d], (d == 0 ? GAP_A : GAP_B) + 1);
                gm_active[d] = 1'b0;
            end
        end
        if (|(acc[d] & src_tlast[d])) begin
            gm_active[d] = 1'b1;
            gm_cnt[d]    = 0;
        end
    endtask

    task automatic advance(input int d);
        logic [BW:0] w;
        for (int s = 0; s < NS; s++) begin
            if (acc[d][s]) begin
                w = src_mem[d][s][src_rd[d][s]];
                src_rd[d][s]++;
                owner[d] = w[DW+KW] ? -1 : s;
            end
        end
    endtask

    task automatic cycle();
        @(negedge eth_clk);
        cyc++;
        for (int d = 0; d < 2; d++) sample(d);
        @(posedge eth_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            advance(d);
            drive(d);
        end
    endtask

    function automatic bit pending();
        pending = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < NS; s++)
                if (src_rd[d][s] < src_wr[d][s]) pending = 1'b1;
    endfunction

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || pending()) && n < 3000) begin
            cycle();
            n++;
        end
        check({tag, "_drain_timeout"}, (n >= 3000), 0);
        repeat (2) cycle();
    endtask

    task automatic end_test(input string tag, input int d);
        int left;
        left = (d == 0) ? exp_q0.size() : exp_q1.size();
        check({tag, "_frame_cnt"}, frame_cnt[d], exp_frames[d]);
        check({tag, "_exp_left"}, left, 0);
    endtask

    // ---------------- tests ----------------
    initial begin
        int n;
        clear_state();

        // 1: single 8-beat frame from source 0, short final keep
        do_reset();
        add_frame(0, 0, 8, 8'h0F);
        model(0);
        wait_done("t1");
        check("t1_latency", lat_out[0] - lat_in[0], 2);
        end_test("t1", 0);

        // 2: three frames per source, back-to-back, must alternate 0,1,0,1,...
        do_reset();
        meas_en = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < NS; s++) add_frame(0, s, $urandom_range(1, 8), 8'h00);
        model(0);
        wait_done("t2");
        end_test("t2", 0);

        // 3: source 1 arrives mid-frame of source 0
        do_reset();
        meas_en = 1'b1;
        add_frame(0, 0, 8, 8'h00);
        add_frame(0, 1, 5, 8'h00);
        hold[0][1] = 1'b1;
        model(0);
        n = 0;
        while (src_rd[0][0] < 3 && n < 500) begin cycle(); n++; end
        check("t3_wait_timeout", (n >= 500), 0);
        hold[0][1] = 1'b0;
        wait_done("t3");
        end_test("t3", 0);
        check("t3_grant_id", grant_id[0], 1);

        // 4: random MAC backpressure and mid-frame source bubbles
        do_reset();
        rand_rdy = 1'b1;
        bubbles  = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < NS; s++) add_frame(0, s, $urandom_range(1, 8), 8'h00);
        model(0);
        wait_done("t4");
        end_test("t4", 0);

        // 5: 12-cycle gap instance
        do_reset();
        meas_en = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < NS; s++) add_frame(1, s, $urandom_range(1, 6), 8'h00);
        model(1);
        wait_done("t5");
        check("t5_latency", lat_out[1] - lat_in[1], 2);
        end_test("t5", 1);

        // 6: reset at beat 4 of an 8-beat frame, then a clean frame from source 1
        do_reset();
        add_frame(0, 0, 1, 8'h00);
        add_frame(0, 0, 8, 8'h00);
        model(0);
        n = 0;
        while (src_rd[0][0] < 5 && n < 500) begin cycle(); n++; end
        check("t6_wait_timeout", (n >= 500), 0);
        check("t6_frame_cnt_pre", frame_cnt[0], 1);
        sys_rst = 1'b1;
        #1;
        check("t6_rst_tvalid", eth_tx_tvalid[0], 0);
        check("t6_rst_frame_cnt", frame_cnt[0], 0);
        check("t6_rst_src_tready", src_tready[0], 0);
        do_reset();
        add_frame(0, 1, 6, 8'h00);
        model(0);
        wait_done("t6");
        end_test("t6", 0);
        check("t6_grant_id", grant_id[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
